chan_demux: RTL and testbench

- Registered, parametrised 1-to-NUM_CH word demultiplexer.
- Replaces the level-steered two-output splitter with a clocked valid/ready design.
- Routes each accepted input word to one output channel. Routing is either round-robin or an explicit per-word select.
- Sits between a word producer and per-channel consumers in the datapath. Each channel has its own one-deep output register and backpressure.

---
 rtl/chan_demux_pkg.sv | 11 +
 rtl/chan_demux_slot.sv | 55 +++++
 rtl/chan_demux.sv | 81 ++++++++
 tb/tb_chan_demux.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chan_demux_pkg.sv
// Shared constants for the chan_demux word demultiplexer: routing mode
// encodings and default word/counter widths.
package chan_demux_pkg;

  localparam logic MODE_RR  = 1'b0;
  localparam logic MODE_SEL = 1'b1;

  localparam int DATA_W_DEF = 32;
  localparam int CNT_W_DEF  = 16;

endpackage

// File: rtl/chan_demux_slot.sv
// One output channel of chan_demux: a one-deep holding register with
// load/retire/valid logic and, under CHAN_DEMUX_CNT_EN, a delivered-word counter.
module chan_demux_slot
  import chan_demux_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] in_data,
  input  logic              ready,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic [CNT_W-1:0]  cnt
);

  logic retire;
  assign retire = valid & ready;

  // NOTE: data is reset because the outputs must read 0 after reset; it is
  // otherwise only written on load, so it keeps its value after a retire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data  <= '0;
      valid <= 1'b0;
    end else begin
      // A load on the same cycle as a retire wins: the new word replaces the old.
      if (load) begin
        data  <= in_data;
        valid <= 1'b1;
      end else if (retire) begin
        valid <= 1'b0;
      end
    end
  end

`ifdef CHAN_DEMUX_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (retire) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt = cnt_q;
`else
  assign cnt = '0;
`endif

endmodule

// File: rtl/chan_demux.sv
// Registered 1-to-NUM_CH valid/ready word demultiplexer with round-robin or
// explicit-select routing. Optional per-channel counters: CHAN_DEMUX_CNT_EN.
module chan_demux
  import chan_demux_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int NUM_CH = 2,
  parameter  int CNT_W  = CNT_W_DEF,
  localparam int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mode,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready,
  output logic [SEL_W-1:0]         rr_ptr,
  output logic                     sel_err,
  output logic [NUM_CH*CNT_W-1:0]  cnt_out
);

  localparam logic [SEL_W:0]   CH_LIMIT = (SEL_W + 1)'(NUM_CH);
  localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(NUM_CH - 1);

  logic [SEL_W-1:0]  tgt;
  logic              tgt_bad;
  logic [NUM_CH-1:0] tgt_hit;
  logic [NUM_CH-1:0] load;
  logic              accept;

  assign tgt     = (mode == MODE_SEL) ? in_sel : rr_ptr;
  assign tgt_bad = (mode == MODE_SEL) && ({1'b0, in_sel} >= CH_LIMIT);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    tgt_hit = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      tgt_hit[k] = !tgt_bad && (tgt == SEL_W'(k));
    end
  end

  // Only the targeted channel can block, and a retiring word frees its slot
  // in the same cycle; an out-of-range select is always accepted and dropped.
  assign in_ready = ~|(tgt_hit & out_valid & ~out_ready);
  assign accept   = in_valid & in_ready;
  assign load     = accept ? tgt_hit : '0;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr  <= '0;
      sel_err <= 1'b0;
    end else begin
      sel_err <= accept & tgt_bad;
      if (accept && (mode == MODE_RR)) begin
        rr_ptr <= (rr_ptr == LAST_CH) ? '0 : rr_ptr + 1'b1;
      end
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
    chan_demux_slot #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
    ) u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (load[k]),
      .in_data (in_data),
      .ready   (out_ready[k]),
      .data    (out_data[k*DATA_W +: DATA_W]),
      .valid   (out_valid[k]),
      .cnt     (cnt_out[k*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_chan_demux.sv
// Directed self-checking bench for chan_demux using three instances
// (NUM_CH = 4, 3 and 2); counter checks follow CHAN_DEMUX_CNT_EN.
module tb_chan_demux;

  localparam int DW = 16;
  localparam int CW = 4;

  logic clk;
  logic rst_n;
  int   compared;
  int   mismatched;

  // Instance A: NUM_CH = 4
  logic          a_mode, a_in_valid, a_in_ready, a_sel_err;
  logic [DW-1:0] a_in_data;
  logic [1:0]    a_in_sel, a_rr_ptr;
  logic [4*DW-1:0] a_out_data;
  logic [3:0]    a_out_valid, a_out_ready;
  logic [4*CW-1:0] a_cnt_out;

  // Instance B: NUM_CH = 3
  logic          b_mode, b_in_valid, b_in_ready, b_sel_err;
  logic [DW-1:0] b_in_data;
  logic [1:0]    b_in_sel, b_rr_ptr;
  logic [3*DW-1:0] b_out_data;
  logic [2:0]    b_out_valid, b_out_ready;
  logic [3*CW-1:0] b_cnt_out;

  // Instance C: NUM_CH = 2
  logic          c_mode, c_in_valid, c_in_ready, c_sel_err;
  logic [DW-1:0] c_in_data;
  logic [0:0]    c_in_sel, c_rr_ptr;
  logic [2*DW-1:0] c_out_data;
  logic [1:0]    c_out_valid, c_out_ready;
  logic [2*CW-1:0] c_cnt_out;

  chan_demux #(.DATA_W(DW), .NUM_CH(4), .CNT_W(CW)) u_a (
    .clk(clk), .rst_n(rst_n), .mode(a_mode), .in_data(a_in_data), .in_sel(a_in_sel),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .out_data(a_out_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .rr_ptr(a_rr_ptr),
    .sel_err(a_sel_err), .cnt_out(a_cnt_out)
  );

  chan_demux #(.DATA_W(DW), .NUM_CH(3), .CNT_W(CW)) u_b (
    .clk(clk), .rst_n(rst_n), .mode(b_mode), .in_data(b_in_data), .in_sel(b_in_sel),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .out_data(b_out_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .rr_ptr(b_rr_ptr),
    .sel_err(b_sel_err), .cnt_out(b_cnt_out)
  );

  chan_demux #(.DATA_W(DW), .NUM_CH(2), .CNT_W(CW)) u_c (
    .clk(clk), .rst_n(rst_n), .mode(c_mode), .in_data(c_in_data), .in_sel(c_in_sel),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .out_data(c_out_data),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .rr_ptr(c_rr_ptr),
    .sel_err(c_sel_err), .cnt_out(c_cnt_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    compared++;
    if (a_out_valid !== 4'h0 || a_rr_ptr !== 2'd0 || a_sel_err !== 1'b0 || a_out_data !== '0) begin
      mismatched++;
      $display("FAIL reset_a: valid=%h rr=%0d err=%b data=%h, want all 0", a_out_valid, a_rr_ptr, a_sel_err, a_out_data);
    end
    compared++;
    if (b_out_valid !== 3'h0 || b_rr_ptr !== 2'd0 || b_sel_err !== 1'b0 || b_out_data !== '0) begin
      mismatched++;
      $display("FAIL reset_b: valid=%h rr=%0d err=%b data=%h, want all 0", b_out_valid, b_rr_ptr, b_sel_err, b_out_data);
    end
    compared++;
    if (c_out_valid !== 2'h0 || c_rr_ptr !== 1'd0 || c_sel_err !== 1'b0 || c_out_data !== '0) begin
      mismatched++;
      $display("FAIL reset_c: valid=%h rr=%0d err=%b data=%h, want all 0", c_out_valid, c_rr_ptr, c_sel_err, c_out_data);
    end
    compared++;
    if (a_cnt_out !== '0 || c_cnt_out !== '0) begin
      mismatched++;
      $display("FAIL reset_cnt: a=%h c=%h, want 0", a_cnt_out, c_cnt_out);
    end
    #9;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_round_robin();
    a_mode = 1'b0;
    a_out_ready = 4'hF;
    a_in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a_in_data = 16'h00A0 + 16'(i);
      #1;
      compared++;
      if (a_in_ready !== 1'b1) begin
        mismatched++;
        $display("FAIL rr_in_ready[%0d]: got %b want 1", i, a_in_ready);
      end
      compared++;
      if (a_rr_ptr !== 2'(i % 4)) begin
        mismatched++;
        $display("FAIL rr_ptr[%0d]: got %0d want %0d", i, a_rr_ptr, i % 4);
      end
      tick();
      compared++;
      if (a_out_valid[i % 4] !== 1'b1 || a_out_data[(i % 4)*DW +: DW] !== 16'h00A0 + 16'(i)) begin
        mismatched++;
        $display("FAIL rr_data[%0d]: ch%0d valid=%b data=%h want 1/%h", i, i % 4,
                 a_out_valid[i % 4], a_out_data[(i % 4)*DW +: DW], 16'h00A0 + 16'(i));
      end
    end
    a_in_valid = 1'b0;
    tick();
    compared++;
    if (a_out_valid !== 4'h0 || a_rr_ptr !== 2'd0) begin
      mismatched++;
      $display("FAIL rr_drain: valid=%h rr=%0d want 0/0", a_out_valid, a_rr_ptr);
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] words [6];
    words = '{16'h0011, 16'h0022, 16'h0033, 16'h0044, 16'h0055, 16'h0066};
    a_mode = 1'b0;
    a_out_ready = 4'b1101;
    a_in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a_in_data = words[i];
      tick();
      if (i == 0) begin
        compared++;
        if (a_out_data[0 +: DW] !== 16'h0011 || a_out_valid[0] !== 1'b1) begin
          mismatched++;
          $display("FAIL bp_ch0: data=%h valid=%b want 0011/1", a_out_data[0 +: DW], a_out_valid[0]);
        end
      end
    end
    a_in_data = words[5];
    for (int i = 0; i < 3; i++) begin
      #1;
      compared++;
      if (a_in_ready !== 1'b0 || a_rr_ptr !== 2'd1) begin
        mismatched++;
        $display("FAIL bp_stall[%0d]: in_ready=%b rr=%0d want 0/1", i, a_in_ready, a_rr_ptr);
      end
      compared++;
      if (a_out_valid[1] !== 1'b1 || a_out_data[DW +: DW] !== 16'h0022) begin
        mismatched++;
        $display("FAIL bp_hold[%0d]: ch1 valid=%b data=%h want 1/0022", i, a_out_valid[1], a_out_data[DW +: DW]);
      end
      tick();
    end
    a_out_ready = 4'hF;
    #1;
    compared++;
    if (a_in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL bp_release: in_ready=%b want 1", a_in_ready);
    end
    tick();
    compared++;
    if (a_out_data[DW +: DW] !== 16'h0066 || a_out_valid[1] !== 1'b1 || a_rr_ptr !== 2'd2) begin
      mismatched++;
      $display("FAIL bp_after: ch1 data=%h valid=%b rr=%0d want 0066/1/2",
               a_out_data[DW +: DW], a_out_valid[1], a_rr_ptr);
    end
    a_in_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_select();
    b_mode = 1'b1;
    b_out_ready = 3'b000;
    b_in_sel = 2'd2;
    b_in_data = 16'hBEEF;
    b_in_valid = 1'b1;
    #1;
    compared++;
    if (b_in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL sel_ready: got %b want 1", b_in_ready);
    end
    tick();
    compared++;
    if (b_out_valid !== 3'b100 || b_out_data[2*DW +: DW] !== 16'hBEEF || b_sel_err !== 1'b0) begin
      mismatched++;
      $display("FAIL sel_load: valid=%b ch2=%h err=%b want 100/beef/0", b_out_valid, b_out_data[2*DW +: DW], b_sel_err);
    end
    #1;
    compared++;
    if (b_in_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL sel_busy: in_ready=%b want 0", b_in_ready);
    end
    b_in_sel = 2'd3;
    b_in_data = 16'hDEAD;
    #1;
    compared++;
    if (b_in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL sel_bad_ready: got %b want 1", b_in_ready);
    end
    tick();
    compared++;
    if (b_sel_err !== 1'b1 || b_out_valid !== 3'b100 || b_out_data !== {16'hBEEF, 16'h0000, 16'h0000}) begin
      mismatched++;
      $display("FAIL sel_drop: err=%b valid=%b data=%h want 1/100/beef00000000", b_sel_err, b_out_valid, b_out_data);
    end
    b_in_valid = 1'b0;
    tick();
    compared++;
    if (b_sel_err !== 1'b0 || b_rr_ptr !== 2'd0) begin
      mismatched++;
      $display("FAIL sel_pulse: err=%b rr=%0d want 0/0", b_sel_err, b_rr_ptr);
    end
  endtask

  task automatic test_back_to_back();
    c_mode = 1'b1;
    c_in_sel = 1'b0;
    c_out_ready = 2'b00;
    c_in_data = 16'h0005;
    c_in_valid = 1'b1;
    tick();
    compared++;
    if (c_out_valid[0] !== 1'b1 || c_out_data[0 +: DW] !== 16'h0005) begin
      mismatched++;
      $display("FAIL b2b_setup: valid=%b data=%h want 1/0005", c_out_valid[0], c_out_data[0 +: DW]);
    end
    c_out_ready = 2'b01;
    c_in_data = 16'h0006;
    #1;
    compared++;
    if (c_in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL b2b_ready: got %b want 1", c_in_ready);
    end
    tick();
    compared++;
    if (c_out_valid[0] !== 1'b1 || c_out_data[0 +: DW] !== 16'h0006) begin
      mismatched++;
      $display("FAIL b2b_swap: valid=%b data=%h want 1/0006", c_out_valid[0], c_out_data[0 +: DW]);
    end
    c_in_valid = 1'b0;
    tick();
    compared++;
    if (c_out_valid[0] !== 1'b0 || c_out_data[0 +: DW] !== 16'h0006 || c_rr_ptr !== 1'b0) begin
      mismatched++;
      $display("FAIL b2b_retire: valid=%b data=%h rr=%0d want 0/0006/0", c_out_valid[0], c_out_data[0 +: DW], c_rr_ptr);
    end
  endtask

  task automatic test_reset_mid();
    a_mode = 1'b0;
    a_out_ready = 4'h0;
    a_in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_in_data = 16'h0C00 + 16'(i);
      tick();
    end
    a_in_valid = 1'b0;
    compared++;
    if (a_out_valid !== 4'hF || a_rr_ptr !== 2'd2) begin
      mismatched++;
      $display("FAIL mid_fill: valid=%h rr=%0d want f/2", a_out_valid, a_rr_ptr);
    end
    #2;
    rst_n = 1'b0;
    #1;
    compared++;
    if (a_out_valid !== 4'h0 || a_rr_ptr !== 2'd0 || a_out_data !== '0 || a_sel_err !== 1'b0) begin
      mismatched++;
      $display("FAIL mid_reset: valid=%h rr=%0d data=%h err=%b want all 0", a_out_valid, a_rr_ptr, a_out_data, a_sel_err);
    end
    compared++;
    if (c_out_data !== '0) begin
      mismatched++;
      $display("FAIL mid_reset_c: data=%h want 0", c_out_data);
    end
    a_out_ready = 4'hF;
    #3;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_counter();
    logic [CW-1:0] exp_cnt;
`ifdef CHAN_DEMUX_CNT_EN
    exp_cnt = 4'd1;
`else
    exp_cnt = 4'd0;
`endif
    c_mode = 1'b1;
    c_in_sel = 1'b0;
    c_out_ready = 2'b11;
    c_in_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      c_in_data = 16'(i);
      tick();
    end
    c_in_valid = 1'b0;
    tick();
    tick();
    compared++;
    if (c_cnt_out[0 +: CW] !== exp_cnt) begin
      mismatched++;
      $display("FAIL cnt_wrap: ch0 count=%0d want %0d", c_cnt_out[0 +: CW], exp_cnt);
    end
    compared++;
    if (c_cnt_out[CW +: CW] !== 4'd0 || c_out_valid !== 2'b00) begin
      mismatched++;
      $display("FAIL cnt_ch1: ch1 count=%0d valid=%b want 0/00", c_cnt_out[CW +: CW], c_out_valid);
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n = 1'b0;
    a_mode = 1'b0; a_in_data = '0; a_in_sel = '0; a_in_valid = 1'b0; a_out_ready = '0;
    b_mode = 1'b0; b_in_data = '0; b_in_sel = '0; b_in_valid = 1'b0; b_out_ready = '0;
    c_mode = 1'b0; c_in_data = '0; c_in_sel = '0; c_in_valid = 1'b0; c_out_ready = '0;

    test_reset();
    test_round_robin();
    test_backpressure();
    test_select();
    test_back_to_back();
    test_reset_mid();
    test_counter();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
